// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and status-flag bit positions for the
// sequential ALU and its multiplier.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;
    localparam logic [3:0] ALU_CMP = 4'd8;
    localparam logic [3:0] ALU_MV  = 4'd15;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } alu_state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register file, the ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             c_flag;
    logic             z_flag;
    logic             n_flag;
    logic             v_flag;

    modport master (
        output start, op, in1, in2,
        input  out, busy, done, c_flag, z_flag, n_flag, v_flag
    );

    modport slave (
        input  start, op, in1, in2,
        output out, busy, done, c_flag, z_flag, n_flag, v_flag
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier datapath: one partial-product accumulation per step.
// prod_next is the accumulator after the current step, so the final product
// can be captured on the same edge as the last iteration.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign prod_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (step) begin
            acc    <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered-output ALU: single-cycle arithmetic/logic/shift/compare ops plus
// an iterative multiply sequenced by a two-state FSM.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    alu_state_t state, state_next;

    logic [WIDTH-1:0]   out_q, res_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q;
    logic [SHW-1:0]     cnt;
    logic               accept, load, step, finish;
    logic               upd_zn;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH:0]     sum, diff, shl_ext, shr_ext;
    logic [SHW-1:0]     amt;
    logic               a_msb, b_msb;

    assign amt     = bus.in2[SHW-1:0];
    assign a_msb   = bus.in1[WIDTH-1];
    assign b_msb   = bus.in2[WIDTH-1];
    assign sum     = {1'b0, bus.in1} + {1'b0, bus.in2};
    assign diff    = {1'b0, bus.in1} - {1'b0, bus.in2};
    // One spare bit on each shift catches the last bit pushed out for C.
    assign shl_ext = {1'b0, bus.in1} << amt;
    assign shr_ext = {bus.in1, 1'b0} >> amt;

    always_comb begin
        res_d   = out_q;
        flags_d = flags_q;
        upd_zn  = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                res_d          = sum[WIDTH-1:0];
                flags_d[FLAG_C] = sum[WIDTH];
                flags_d[FLAG_V] = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
                upd_zn         = 1'b1;
            end
            ALU_SUB, ALU_CMP: begin
                if (bus.op == ALU_SUB) res_d = diff[WIDTH-1:0];
                flags_d[FLAG_C] = diff[WIDTH];
                flags_d[FLAG_V] = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
                flags_d[FLAG_Z] = ~|diff[WIDTH-1:0];
                flags_d[FLAG_N] = diff[WIDTH-1];
            end
            ALU_AND: begin res_d = bus.in1 & bus.in2; upd_zn = 1'b1; end
            ALU_OR:  begin res_d = bus.in1 | bus.in2; upd_zn = 1'b1; end
            ALU_XOR: begin res_d = bus.in1 ^ bus.in2; upd_zn = 1'b1; end
            ALU_SHL: begin
                res_d           = shl_ext[WIDTH-1:0];
                flags_d[FLAG_C] = shl_ext[WIDTH];
                upd_zn          = 1'b1;
            end
            ALU_SHR: begin
                res_d           = shr_ext[WIDTH:1];
                flags_d[FLAG_C] = shr_ext[0];
                upd_zn          = 1'b1;
            end
            ALU_MV:  res_d = bus.in1;
            default: ;
        endcase
        if (upd_zn) begin
            flags_d[FLAG_Z] = ~|res_d;
            flags_d[FLAG_N] = res_d[WIDTH-1];
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == ALU_MUL) begin
                        load       = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // MUL leaves V untouched; C reports a non-zero upper product half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            out_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            state  <= state_next;
            done_q <= accept | finish;
            if (load) cnt <= '0;
            else if (step) cnt <= cnt + SHW'(1);
            if (accept) begin
                out_q   <= res_d;
                flags_q <= flags_d;
            end else if (finish) begin
                out_q           <= prod_next[WIDTH-1:0];
                flags_q[FLAG_C] <= |prod_next[2*WIDTH-1:WIDTH];
                flags_q[FLAG_Z] <= ~|prod_next[WIDTH-1:0];
                flags_q[FLAG_N] <= prod_next[WIDTH-1];
            end
        end
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .a         (bus.in1),
        .b         (bus.in2),
        .prod_next (prod_next)
    );

    assign bus.out    = out_q;
    assign bus.busy   = (state == ST_MUL);
    assign bus.done   = done_q;
    assign bus.c_flag = flags_q[FLAG_C];
    assign bus.z_flag = flags_q[FLAG_Z];
    assign bus.n_flag = flags_q[FLAG_N];
    assign bus.v_flag = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed corner cases plus random ops, with a queue-based
// scoreboard fed by an arithmetic reference model and drained on each done.
module tb_alu_seq;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] out;
        logic [3:0]   flags;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    logic [W-1:0] m_out   = '0;
    logic [3:0]   m_flags = '0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] dut_flags();
        return {bus.c_flag, bus.z_flag, bus.n_flag, bus.v_flag};
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model; flags packed as {C,Z,N,V}.
    task automatic modelIssue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint r;
        int     sa = $signed(a);
        int     sbv = $signed(b);
        int     sr;
        int     amt = int'(b[3:0]);
        logic   c, z, n, v;
        logic   zn;
        {c, z, n, v} = m_flags;
        zn = 1'b1;
        case (op)
            4'd0: begin
                r = ua + ub; sr = sa + sbv;
                m_out = r[W-1:0]; c = (r >= 65536); v = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                sr = sa - sbv;
                m_out = a - b; c = (ua < ub); v = (sr > 32767) || (sr < -32768);
            end
            4'd2: m_out = a & b;
            4'd3: m_out = a | b;
            4'd4: m_out = a ^ b;
            4'd5: begin
                r = ua << amt; m_out = r[W-1:0];
                c = (amt == 0) ? 1'b0 : r[16];
            end
            4'd6: begin
                m_out = a >> amt;
                c = (amt == 0) ? 1'b0 : (((ua >> (amt - 1)) & 1) != 0);
            end
            4'd7: begin
                r = ua * ub; m_out = r[W-1:0]; c = ((r >> 16) != 0);
            end
            4'd8: begin
                sr = sa - sbv;
                c = (ua < ub); v = (sr > 32767) || (sr < -32768);
                z = (a == b); n = sr[15];
                zn = 1'b0;
            end
            4'd15: begin m_out = a; zn = 1'b0; end
            default: zn = 1'b0;
        endcase
        if (zn) begin
            z = (m_out == 0);
            n = m_out[W-1];
        end
        m_flags = {c, z, n, v};
        sb.push_back('{m_out, m_flags});
    endtask

    // Presents one op for a single edge; returns just after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.in1   = a;
        bus.in2   = b;
        modelIssue(op, a, b);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (op == 4'd7) checkOutput("mul_busy_start", {15'd0, bus.busy}, 16'd1);
        else            checkOutput("latency1_done", {15'd0, bus.done}, 16'd1);
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while ((bus.busy || sb.size() != 0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy || sb.size() != 0) begin
            failed++;
            tests++;
            $display("[TB] FAIL wait_idle: busy=%0d pending=%0d after %0d cycles", bus.busy, sb.size(), n);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL unexpected_done: got done=1, expected 0 (no pending op)");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_out", bus.out, e.out);
                checkOutput("sb_flags", {12'd0, dut_flags()}, {12'd0, e.flags});
            end
        end
    end

    initial begin
        int busy_cycles;
        logic [3:0] rop;
        logic [W-1:0] ra, rb;

        bus.start = 1'b0;
        bus.op    = '0;
        bus.in1   = '0;
        bus.in2   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out", bus.out, 16'h0000);
        checkOutput("reset_flags", {12'd0, dut_flags()}, 16'h0000);
        checkOutput("reset_busy", {15'd0, bus.busy}, 16'd0);
        checkOutput("reset_done", {15'd0, bus.done}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(4'd0, 16'hFFFF, 16'h0001);
        checkOutput("add_wrap_out", bus.out, 16'h0000);
        checkOutput("add_wrap_flags", {12'd0, dut_flags()}, 16'b1100);
        applyStimulus(4'd0, 16'h7FFF, 16'h0001);
        checkOutput("add_ovf_out", bus.out, 16'h8000);
        checkOutput("add_ovf_flags", {12'd0, dut_flags()}, 16'b0011);
        applyStimulus(4'd1, 16'd3, 16'd5);
        checkOutput("sub_out", bus.out, 16'hFFFE);
        checkOutput("sub_flags", {12'd0, dut_flags()}, 16'b1010);
        applyStimulus(4'd8, 16'd5, 16'd5);
        checkOutput("cmp_out", bus.out, 16'hFFFE);
        checkOutput("cmp_flags", {12'd0, dut_flags()}, 16'b0100);
        applyStimulus(4'd15, 16'h1234, 16'hAAAA);
        checkOutput("mv_out", bus.out, 16'h1234);
        checkOutput("mv_flags", {12'd0, dut_flags()}, 16'b0100);
        applyStimulus(4'd5, 16'h8001, 16'd1);
        checkOutput("shl_out", bus.out, 16'h0002);
        checkOutput("shl_flags", {12'd0, dut_flags()}, 16'b1000);
        applyStimulus(4'd6, 16'h0001, 16'd0);
        checkOutput("shr0_out", bus.out, 16'h0001);
        checkOutput("shr0_flags", {12'd0, dut_flags()}, 16'b0000);
        waitIdle(10);

        // MUL timing, with a start that must be ignored while busy.
        applyStimulus(4'd7, 16'd300, 16'd300);
        busy_cycles = 0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            bus.start = (g == 4);
            bus.op    = 4'd0;
            bus.in1   = 16'd1;
            bus.in2   = 16'd1;
            if (bus.done) break;
            if (bus.busy) busy_cycles++;
        end
        bus.start = 1'b0;
        checkOutput("mul_busy_cycles", 16'(busy_cycles), 16'd16);
        checkOutput("mul_out", bus.out, 16'h5F90);
        checkOutput("mul_flags", {12'd0, dut_flags()}, 16'b1000);
        repeat (4) @(negedge clk);
        waitIdle(10);

        applyStimulus(4'd0, 16'h0010, 16'h0020);
        applyStimulus(4'd4, 16'hFFFF, 16'h0F0F);
        applyStimulus(4'd11, 16'h5555, 16'h1111);
        checkOutput("nop_out", bus.out, 16'hF0F0);
        checkOutput("nop_flags", {12'd0, dut_flags()}, 16'b0010);
        waitIdle(10);

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(4'd7, 16'd1234, 16'd77);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_out", bus.out, 16'h0000);
        checkOutput("rst_mid_flags", {12'd0, dut_flags()}, 16'h0000);
        checkOutput("rst_mid_busy", {15'd0, bus.busy}, 16'd0);
        sb.delete();
        m_out   = '0;
        m_flags = '0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'd0, 16'd1, 16'd1);
        checkOutput("post_rst_add", bus.out, 16'd2);
        waitIdle(10);

        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            applyStimulus(rop, ra, rb);
            if (rop == 4'd7) waitIdle(40);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        waitIdle(60);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
